// File: rtl/step_cnt_pkg.sv
// step_cnt_pkg: shared constants and types for the delayed-enable step counter.
// Rev 1.0
`default_nettype none

package step_cnt_pkg;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DN    = 1'b0;

  localparam int   DEF_WIDTH = 5;
  localparam int   DEF_DELAY = 2;
  localparam int   MAX_DELAY = 7;

  // One enable-pipeline slot: the count enable and the direction travel together.
  typedef struct packed {
    logic ce;
    logic dir;
  } ce_pipe_t;

endpackage : step_cnt_pkg

`default_nettype wire

// File: rtl/step_cnt_p_if.sv
// step_cnt_p_if: control/status bundle of the step counter (master drives, slave counts).
// Rev 1.0
`default_nettype none

interface step_cnt_p_if
  import step_cnt_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             sclr;
  logic             ce;
  logic             dir;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] cnt;
  logic             tc;
  logic             busy;

  modport master (
    output sclr,
    output ce,
    output dir,
    output load,
    output load_val,
    input  cnt,
    input  tc,
    input  busy
  );

  modport slave (
    input  sclr,
    input  ce,
    input  dir,
    input  load,
    input  load_val,
    output cnt,
    output tc,
    output busy
  );

endinterface : step_cnt_p_if

`default_nettype wire

// File: rtl/step_cnt_p_ce_delay_line.sv
// ce_delay_line: DELAY-stage shift register for {CE,DIR} with async reset, sync flush, BUSY.
// Rev 1.0
`default_nettype none

module ce_delay_line
  import step_cnt_pkg::*;
#(
  parameter int DELAY = DEF_DELAY
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     flush_i,
  input  ce_pipe_t data_i,
  output ce_pipe_t data_o,
  output logic     busy_o
);

  if (DELAY == 0) begin : g_bypass

    assign data_o = data_i;
    assign busy_o = 1'b0;

    // No storage in this configuration; the control inputs are intentionally ignored.
    logic unused_bypass;
    assign unused_bypass = ^{clk_i, rst_ni, flush_i};

  end else begin : g_pipe

    ce_pipe_t [DELAY-1:0] stage_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        stage_q <= '0;
      end else if (flush_i) begin
        stage_q <= '0;
      end else begin
        stage_q[0] <= data_i;
        for (int i = 1; i < DELAY; i++) begin
          stage_q[i] <= stage_q[i-1];
        end
      end
    end

    assign data_o = stage_q[DELAY-1];

    always_comb begin
      busy_o = 1'b0;
      for (int i = 0; i < DELAY; i++) begin
        busy_o = busy_o | stage_q[i].ce;
      end
    end

  end

endmodule : ce_delay_line

`default_nettype wire

// File: rtl/step_cnt_p.sv
// step_cnt_p: up/down step counter with delayed enable; wraps at MAX_VAL, or clamps
// at 0/MAX_VAL when STEP_CNT_SAT_EN is defined.  Rev 1.0
`default_nettype none

module step_cnt_p
  import step_cnt_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int DELAY   = DEF_DELAY,
  parameter int MAX_VAL = 2**WIDTH - 1,
  parameter int STEP    = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  step_cnt_p_if.slave bus
);

  if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
    $fatal(1, "step_cnt_p: WIDTH must be within 2..16");
  end
  if (DELAY < 0 || DELAY > MAX_DELAY) begin : g_bad_delay
    $fatal(1, "step_cnt_p: DELAY must be within 0..7");
  end
  if (MAX_VAL < 1 || MAX_VAL > 2**WIDTH - 1) begin : g_bad_max
    $fatal(1, "step_cnt_p: MAX_VAL must be within 1..2**WIDTH-1");
  end
  if (STEP < 1 || STEP > MAX_VAL) begin : g_bad_step
    $fatal(1, "step_cnt_p: STEP must be within 1..MAX_VAL");
  end

  // One extra bit keeps cnt+STEP and cnt+MAX_VAL+1 exact.
  localparam logic [WIDTH:0] c_max  = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH:0] c_step = (WIDTH+1)'(STEP);
  localparam logic [WIDTH:0] c_mod  = (WIDTH+1)'(MAX_VAL + 1);

  ce_pipe_t         pipe_in;
  ce_pipe_t         pipe_out;
  logic             busy;

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;
  logic             tc_q;
  logic             tc_d;

  logic [WIDTH:0]   cnt_x;
  logic [WIDTH-1:0] step_nxt;
  logic             step_tc;

  assign pipe_in = ce_pipe_t'{ce: bus.ce, dir: bus.dir};

  ce_delay_line #(
    .DELAY (DELAY)
  ) u_ce_delay_line (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (bus.sclr),
    .data_i  (pipe_in),
    .data_o  (pipe_out),
    .busy_o  (busy)
  );

  assign cnt_x = {1'b0, cnt_q};

  always_comb begin
    step_nxt = cnt_q;
    step_tc  = 1'b0;
    case (pipe_out.dir)
      DIR_UP: begin
`ifdef STEP_CNT_SAT_EN
        if (cnt_x + c_step >= c_max) begin
          step_nxt = WIDTH'(c_max);
          step_tc  = 1'b1;
        end else begin
          step_nxt = WIDTH'(cnt_x + c_step);
        end
`else
        if (cnt_x > c_max - c_step) begin
          step_nxt = WIDTH'(cnt_x + c_step - c_mod);
          step_tc  = 1'b1;
        end else begin
          step_nxt = WIDTH'(cnt_x + c_step);
        end
`endif
      end
      DIR_DN: begin
`ifdef STEP_CNT_SAT_EN
        if (cnt_x <= c_step) begin
          step_nxt = '0;
          step_tc  = 1'b1;
        end else begin
          step_nxt = WIDTH'(cnt_x - c_step);
        end
`else
        if (cnt_x < c_step) begin
          step_nxt = WIDTH'(cnt_x + c_mod - c_step);
          step_tc  = 1'b1;
        end else begin
          step_nxt = WIDTH'(cnt_x - c_step);
        end
`endif
      end
    endcase
  end

  // A delayed enable landing on a LOAD edge is dropped, not deferred.
  always_comb begin
    cnt_d = cnt_q;
    tc_d  = 1'b0;
    if (bus.sclr) begin
      cnt_d = '0;
    end else if (bus.load) begin
      if ({1'b0, bus.load_val} > c_max) begin
        cnt_d = WIDTH'(c_max);
      end else begin
        cnt_d = bus.load_val;
      end
    end else if (pipe_out.ce) begin
      cnt_d = step_nxt;
      tc_d  = step_tc;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      tc_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
    end
  end

  assign bus.cnt  = cnt_q;
  assign bus.tc   = tc_q;
  assign bus.busy = busy;

endmodule : step_cnt_p

`default_nettype wire

// File: tb/tb_step_cnt_p.sv
// tb_step_cnt_p: directed bench for step_cnt_p (default instance and MAX_VAL=9/STEP=3 instance).
// Rev 1.0
`default_nettype none

module tb_step_cnt_p;
  import step_cnt_pkg::*;

  localparam int W      = 5;
  localparam int DLY    = 2;
  localparam int MAX_A  = 31;
  localparam int STEP_A = 1;
  localparam int MAX_B  = 9;
  localparam int STEP_B = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  step_cnt_p_if #(.WIDTH(W)) bus_a ();
  step_cnt_p_if #(.WIDTH(W)) bus_b ();

  step_cnt_p #(
    .WIDTH (W),
    .DELAY (DLY)
  ) u_dut_a (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus_a)
  );

  step_cnt_p #(
    .WIDTH   (W),
    .DELAY   (DLY),
    .MAX_VAL (MAX_B),
    .STEP    (STEP_B)
  ) u_dut_b (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus_b)
  );

  int checks   = 0;
  int failures = 0;

  // Model: counts edges, logs every sampled CE/DIR, and looks back DLY edges.
  // A sample is void if a clear (SCLR or reset) happened at or after its edge.
  int cyc = 0;
  int m_cnt    [2];
  bit m_tc     [2];
  bit m_busy   [2];
  int last_clr [2];
  bit ce_log   [2][64];
  bit dir_log  [2][64];

  function automatic int max_of(input int d);
    return (d == 0) ? MAX_A : MAX_B;
  endfunction

  function automatic int step_of(input int d);
    return (d == 0) ? STEP_A : STEP_B;
  endfunction

  function automatic void step_model(input int cnt, input bit up, input int maxv,
                                     input int stp, output int nxt, output bit tc);
`ifdef STEP_CNT_SAT_EN
    nxt = up ? cnt + stp : cnt - stp;
    tc  = 1'b0;
    if (up && nxt >= maxv) begin
      nxt = maxv;
      tc  = 1'b1;
    end else if (!up && nxt <= 0) begin
      nxt = 0;
      tc  = 1'b1;
    end
`else
    nxt = up ? cnt + stp : cnt - stp;
    tc  = 1'b0;
    if (nxt > maxv) begin
      nxt = nxt - (maxv + 1);
      tc  = 1'b1;
    end else if (nxt < 0) begin
      nxt = nxt + (maxv + 1);
      tc  = 1'b1;
    end
`endif
  endfunction

  task automatic model_edge(input int d, input bit sclr, input bit load, input int lv,
                            input bit ce, input bit dir);
    int k;
    int j;
    int nxt;
    bit eff_ce;
    bit eff_up;
    bit tcv;
    k = cyc;
    ce_log[d][k % 64]  = ce;
    dir_log[d][k % 64] = dir;
    j      = k - DLY;
    eff_ce = 1'b0;
    eff_up = 1'b0;
    if (j > last_clr[d]) begin
      eff_ce = ce_log[d][j % 64];
      eff_up = dir_log[d][j % 64];
    end
    if (sclr) begin
      m_cnt[d]    = 0;
      m_tc[d]     = 1'b0;
      last_clr[d] = k;
    end else if (load) begin
      m_cnt[d] = (lv > max_of(d)) ? max_of(d) : lv;
      m_tc[d]  = 1'b0;
    end else if (eff_ce) begin
      step_model(m_cnt[d], eff_up, max_of(d), step_of(d), nxt, tcv);
      m_cnt[d] = nxt;
      m_tc[d]  = tcv;
    end else begin
      m_tc[d] = 1'b0;
    end
    m_busy[d] = 1'b0;
    for (int i = k - DLY + 1; i <= k; i++) begin
      if (i > last_clr[d]) begin
        if (ce_log[d][i % 64]) m_busy[d] = 1'b1;
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        m_cnt[d]    = 0;
        m_tc[d]     = 1'b0;
        m_busy[d]   = 1'b0;
        last_clr[d] = cyc;
      end
    end else begin
      cyc = cyc + 1;
      model_edge(0, bus_a.sclr, bus_a.load, int'(bus_a.load_val), bus_a.ce, bus_a.dir);
      model_edge(1, bus_b.sclr, bus_b.load, int'(bus_b.load_val), bus_b.ce, bus_b.dir);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input int exp);
    checks++;
    if (act !== 32'(exp)) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_all();
    chk("A.cnt",  32'(bus_a.cnt),  m_cnt[0]);
    chk("A.tc",   32'(bus_a.tc),   int'(m_tc[0]));
    chk("A.busy", 32'(bus_a.busy), int'(m_busy[0]));
    chk("B.cnt",  32'(bus_b.cnt),  m_cnt[1]);
    chk("B.tc",   32'(bus_b.tc),   int'(m_tc[1]));
    chk("B.busy", 32'(bus_b.busy), int'(m_busy[1]));
  endtask

  task automatic tick();
    @(negedge clk);
    cmp_all();
  endtask

  initial begin
    bus_a.sclr = 1'b0; bus_a.ce = 1'b1; bus_a.dir = DIR_UP; bus_a.load = 1'b0; bus_a.load_val = '0;
    bus_b.sclr = 1'b0; bus_b.ce = 1'b1; bus_b.dir = DIR_UP; bus_b.load = 1'b0; bus_b.load_val = '0;

    // CE held high during reset must leave no trace.
    repeat (3) tick();
    rst_n    = 1'b1;
    bus_a.ce = 1'b0;
    bus_b.ce = 1'b0;
    repeat (3) tick();
    chk("lit.reset_cnt",  32'(bus_a.cnt),  0);
    chk("lit.reset_tc",   32'(bus_a.tc),   0);
    chk("lit.reset_busy", 32'(bus_a.busy), 0);
    chk("lit.reset_cntB", 32'(bus_b.cnt),  0);

    // Single CE: step lands two edges later, BUSY covers the gap.
    bus_a.ce = 1'b1; bus_a.dir = DIR_UP;
    tick();
    chk("lit.d1_busy", 32'(bus_a.busy), 1);
    chk("lit.d1_cnt",  32'(bus_a.cnt),  0);
    bus_a.ce = 1'b0;
    tick();
    chk("lit.d2_busy", 32'(bus_a.busy), 1);
    chk("lit.d2_cnt",  32'(bus_a.cnt),  0);
    tick();
    chk("lit.d3_cnt",  32'(bus_a.cnt),  1);
    chk("lit.d3_busy", 32'(bus_a.busy), 0);

    // Load 30 then three back-to-back CE up.
    bus_a.load = 1'b1; bus_a.load_val = 5'd30;
    tick();
    chk("lit.load30", 32'(bus_a.cnt), 30);
    bus_a.load = 1'b0; bus_a.ce = 1'b1;
    tick();
    tick();
    tick();
    bus_a.ce = 1'b0;
`ifdef STEP_CNT_SAT_EN
    chk("lit.up1_cnt", 32'(bus_a.cnt), 31);
    chk("lit.up1_tc",  32'(bus_a.tc),  1);
    tick();
    chk("lit.up2_cnt", 32'(bus_a.cnt), 31);
    chk("lit.up2_tc",  32'(bus_a.tc),  1);
    tick();
    chk("lit.up3_cnt", 32'(bus_a.cnt), 31);
    chk("lit.up3_tc",  32'(bus_a.tc),  1);
`else
    chk("lit.up1_cnt", 32'(bus_a.cnt), 31);
    chk("lit.up1_tc",  32'(bus_a.tc),  0);
    tick();
    chk("lit.up2_cnt", 32'(bus_a.cnt), 0);
    chk("lit.up2_tc",  32'(bus_a.tc),  1);
    tick();
    chk("lit.up3_cnt", 32'(bus_a.cnt), 1);
    chk("lit.up3_tc",  32'(bus_a.tc),  0);
`endif
    tick();
    chk("lit.up_idle_tc", 32'(bus_a.tc), 0);

    // Two CE in flight, then SCLR flushes them.
    bus_a.ce = 1'b1;
    tick();
    tick();
    chk("lit.fl_busy_pre", 32'(bus_a.busy), 1);
    bus_a.ce = 1'b0; bus_a.sclr = 1'b1;
    tick();
    chk("lit.fl_cnt",  32'(bus_a.cnt),  0);
    chk("lit.fl_busy", 32'(bus_a.busy), 0);
    bus_a.sclr = 1'b0;
    repeat (3) tick();
    chk("lit.fl_after", 32'(bus_a.cnt), 0);

    // Down step from 0.
    bus_a.dir = DIR_DN; bus_a.ce = 1'b1;
    tick();
    bus_a.ce = 1'b0;
    tick();
    tick();
`ifdef STEP_CNT_SAT_EN
    chk("lit.dn0_cnt", 32'(bus_a.cnt), 0);
`else
    chk("lit.dn0_cnt", 32'(bus_a.cnt), 31);
`endif
    chk("lit.dn0_tc", 32'(bus_a.tc), 1);
    tick();

    // LOAD on the edge where the delayed CE arrives: the step is dropped.
    bus_a.dir = DIR_UP; bus_a.ce = 1'b1;
    tick();
    bus_a.ce = 1'b0;
    tick();
    bus_a.load = 1'b1; bus_a.load_val = 5'd5;
    tick();
    chk("lit.ldrop", 32'(bus_a.cnt), 5);
    bus_a.load = 1'b0;
    tick();
    chk("lit.ldrop_hold", 32'(bus_a.cnt), 5);

    // MAX_VAL=9, STEP=3 instance: down from 1, then clamped load and up from 9.
    bus_b.dir = DIR_DN; bus_b.load = 1'b1; bus_b.load_val = 5'd1;
    tick();
    bus_b.load = 1'b0; bus_b.ce = 1'b1;
    tick();
    bus_b.ce = 1'b0;
    tick();
    tick();
`ifdef STEP_CNT_SAT_EN
    chk("lit.b_dn_cnt", 32'(bus_b.cnt), 0);
`else
    chk("lit.b_dn_cnt", 32'(bus_b.cnt), 8);
`endif
    chk("lit.b_dn_tc", 32'(bus_b.tc), 1);
    bus_b.load = 1'b1; bus_b.load_val = 5'd20;
    tick();
    chk("lit.b_clamp", 32'(bus_b.cnt), 9);
    bus_b.load = 1'b0; bus_b.dir = DIR_UP; bus_b.ce = 1'b1;
    tick();
    bus_b.ce = 1'b0;
    tick();
    tick();
`ifdef STEP_CNT_SAT_EN
    chk("lit.b_up_cnt", 32'(bus_b.cnt), 9);
`else
    chk("lit.b_up_cnt", 32'(bus_b.cnt), 2);
`endif
    chk("lit.b_up_tc", 32'(bus_b.tc), 1);

    // Asynchronous reset mid-count with a CE in flight.
    bus_a.load = 1'b1; bus_a.load_val = 5'd17;
    tick();
    bus_a.load = 1'b0; bus_a.ce = 1'b1;
    tick();
    chk("lit.r_pre_cnt",  32'(bus_a.cnt),  17);
    chk("lit.r_pre_busy", 32'(bus_a.busy), 1);
    bus_a.ce = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("lit.r_cnt",  32'(bus_a.cnt),  0);
    chk("lit.r_tc",   32'(bus_a.tc),   0);
    chk("lit.r_busy", 32'(bus_a.busy), 0);
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    chk("lit.r_after_cnt",  32'(bus_a.cnt),  0);
    chk("lit.r_after_busy", 32'(bus_a.busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_step_cnt_p

`default_nettype wire

// File: doc/step_cnt_p.md
STEP_CNT_P -- requirements
Module: step_cnt_p

Interface
REQ-001 Parameter WIDTH, 5, counter width in bits (2..16).
REQ-002 Parameter DELAY, 2, enable pipeline depth in cycles (0..7).
REQ-003 Parameter MAX_VAL, 2**WIDTH-1, terminal (wrap) value; SHALL be at most 2**WIDTH-1.
REQ-004 Parameter STEP, 1, increment magnitude; SHALL be 1..MAX_VAL.
REQ-005 CLK  in  1  single clock; all state on rising edge.
REQ-006 RST  in  1  asynchronous, active-low reset.
REQ-007 SCLR  in  1  synchronous clear; also flushes the enable pipeline.
REQ-008 CE  in  1  count enable; enters the DELAY-stage pipeline.
REQ-009 DIR  in  1  direction, 1=up, 0=down; pipelined alongside CE.
REQ-010 LOAD  in  1  synchronous load; not delayed.
REQ-011 LOAD_VAL  in  WIDTH  load value.
REQ-012 CNT  out  WIDTH  registered count.
REQ-013 TC  out  1  registered one-cycle terminal-count pulse.
REQ-014 BUSY  out  1  high while any pipeline stage holds CE=1.

Function
REQ-015 CE/DIR SHALL pass through a DELAY-stage shift register; the stage output (ce_d, dir_d) drives the step; DELAY=0 uses CE/DIR directly.
REQ-016 Per-edge priority SHALL be: SCLR > LOAD > ce_d step > hold.
REQ-017 SCLR SHALL set CNT=0, TC=0 and clear all pipeline stages on the same edge.
REQ-018 LOAD SHALL set CNT=min(LOAD_VAL, MAX_VAL) and TC=0; pipeline contents keep shifting, and a ce_d coinciding with LOAD is dropped.
REQ-019 Up step: if CNT > MAX_VAL-STEP, next = CNT+STEP-(MAX_VAL+1) and TC=1; else next = CNT+STEP.
REQ-020 Down step: if CNT < STEP, next = CNT+(MAX_VAL+1)-STEP and TC=1; else next = CNT-STEP.
REQ-021 Step arithmetic SHALL use WIDTH+1 bits internally; no intermediate truncation.
REQ-022 TC SHALL be high only in the cycle in which CNT shows the post-wrap value; it is 0 otherwise.
REQ-023 CE pulses back-to-back SHALL each produce one step, exactly DELAY cycles later (throughput one step/cycle).
REQ-024 BUSY SHALL be the OR of the pipeline CE stages; it is 0 when DELAY=0.

Reset
REQ-025 RST low SHALL immediately force CNT=0, TC=0, BUSY=0 and clear all pipeline stages, independent of CLK.
REQ-026 Reset removal SHALL be followed by counting only on CE sampled after removal; CE seen during reset is discarded.

Configuration
REQ-027 Macro STEP_CNT_SAT_EN defined: REQ-019/020 wrap is replaced by clamp (up to MAX_VAL, down to 0); TC pulses on the step that reaches or is clamped at the bound; further steps at the bound hold CNT and pulse TC again.
REQ-028 STEP_CNT_SAT_EN undefined: wrap behaviour per REQ-019/020; no saturation logic synthesised.

Structure
REQ-029 Package step_cnt_pkg SHALL hold the DIR_UP/DIR_DN constants, the default WIDTH/DELAY, and the max-DELAY bound (7).
REQ-030 Sub-module ce_delay_line (parameter DELAY, 2-bit data {CE,DIR}, async reset, sync flush, BUSY output) SHALL implement the pipeline.
REQ-031 Parameter legality (REQ-001..004) SHALL be checked at elaboration with a fatal error.

Verification
REQ-032 Defaults; CE=1 for one cycle at t0 -> CNT 0->1 at t0+2 cycles; BUSY high for the 2 intervening cycles.
REQ-033 Defaults, wrap build; LOAD_VAL=30, then CE held high -> CNT 31, 0 (TC=1 that cycle only), 1.
REQ-034 MAX_VAL=9, STEP=3, DIR=0, LOAD_VAL=1, one CE -> CNT=8, TC=1.
REQ-035 STEP_CNT_SAT_EN build, LOAD_VAL=30, three CE up -> CNT 31, 31, 31, TC pulsing on each step.
REQ-036 Two CE in flight, SCLR asserted -> CNT=0, BUSY=0 next cycle, no later steps.
REQ-037 RST low mid-count (CNT=17, CE in flight) -> CNT=0, TC=0, BUSY=0 asynchronously; no step after release.
